// File: rtl/psum_deskew_collector.sv
// Deskews systolic-array bottom-row partial sums into whole rows and queues them in a DEPTH-row FIFO.
// Optional PSUM_OVF_CNT_EN builds a saturating dropped-row counter on ovf_cnt (tied to 0 otherwise).
module psum_deskew_collector #(
  parameter int WORDWIDTH = 8,
  parameter int COLS      = 4,
  parameter int DEPTH     = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            clear,
  input  logic [COLS-1:0]                 enable_in,
  input  logic [COLS*WORDWIDTH*4-1:0]     ps_in,
  output logic                            row_valid,
  input  logic                            row_ready,
  output logic [COLS*WORDWIDTH*4-1:0]     row_data,
  output logic [$clog2(DEPTH):0]          fifo_count,
  output logic                            overflow,
  output logic                            skew_err,
  output logic [7:0]                      ovf_cnt
);

  localparam int PSW  = WORDWIDTH * 4;
  localparam int ROWW = COLS * PSW;
  localparam int AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [COLS-1:0] al_en;
  logic [ROWW-1:0] al_dat;

  // Column c waits COLS-1-c cycles so every column lines up with the last one.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    if (c == COLS-1) begin : g_pass
      assign al_en[c]               = enable_in[c];
      assign al_dat[c*PSW +: PSW]   = ps_in[c*PSW +: PSW];
    end else begin : g_dly
      localparam int N = COLS - 1 - c;
      logic [N-1:0]     en_sr;
      logic [N*PSW-1:0] dat_sr;

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          en_sr  <= '0;
          dat_sr <= '0;
        end else begin
          en_sr[0]       <= clear ? 1'b0 : enable_in[c];
          dat_sr[0 +: PSW] <= ps_in[c*PSW +: PSW];
          for (int s = 1; s < N; s++) begin
            en_sr[s]             <= clear ? 1'b0 : en_sr[s-1];
            dat_sr[s*PSW +: PSW] <= dat_sr[(s-1)*PSW +: PSW];
          end
        end
      end

      assign al_en[c]             = en_sr[N-1];
      assign al_dat[c*PSW +: PSW] = dat_sr[(N-1)*PSW +: PSW];
    end
  end

  logic [ROWW-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            complete, skew, full, pop, push, drop;

  assign complete = &al_en;
  assign skew     = (|al_en) & ~complete;
  assign full     = (count == FULL_CNT);
  assign pop      = row_valid & row_ready & ~clear;
  // A pop in the same cycle frees the slot the incoming row needs.
  assign push     = complete & (~full | pop) & ~clear;
  assign drop     = complete & full & ~pop & ~clear;

  always_ff @(posedge clk) begin
    if (reset_n && push) mem[wr_ptr] <= al_dat;
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      skew_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
      if (skew) skew_err <= 1'b1;
    end
  end

  assign fifo_count = count;
  assign row_valid  = (count != '0);
  assign row_data   = row_valid ? mem[rd_ptr] : '0;

`ifdef PSUM_OVF_CNT_EN
  logic [7:0] ovf_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n || clear) ovf_cnt_q <= 8'd0;
    else if (drop && ovf_cnt_q != 8'hFF) ovf_cnt_q <= ovf_cnt_q + 8'd1;
  end

  assign ovf_cnt = ovf_cnt_q;
`else
  assign ovf_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_psum_deskew_collector.sv
// Directed bench for psum_deskew_collector: vector table of row bursts plus hand-built corner sequences.
module tb_psum_deskew_collector;
  localparam int COLS  = 4;
  localparam int DEPTH = 4;
  localparam int PSW   = 32;
  localparam int ROWW  = COLS * PSW;

  logic            clk, reset_n, clear, row_ready, row_valid, overflow, skew_err;
  logic [COLS-1:0] enable_in;
  logic [ROWW-1:0] ps_in, row_data;
  logic [2:0]      fifo_count;
  logic [7:0]      ovf_cnt;

  psum_deskew_collector #(.WORDWIDTH(8), .COLS(COLS), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .enable_in(enable_in), .ps_in(ps_in),
    .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
    .fifo_count(fifo_count), .overflow(overflow), .skew_err(skew_err), .ovf_cnt(ovf_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int rid   = 0;
  logic [ROWW-1:0] got [$];

  // Rows popped at the coming edge, captured mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (row_valid && row_ready) got.push_back(row_data);
  end

  typedef struct {
    bit clr;
    int n;
    int skip;
    int cnt;
    bit ovf;
    bit skw;
    int ocnt;
    int head;
  } vec_t;

  function automatic logic [ROWW-1:0] mkrow(input int r);
    logic [ROWW-1:0] v;
    v = '0;
    for (int c = 0; c < COLS; c++) v[c*PSW +: PSW] = PSW'(r*100 + (c+1)*10);
    return v;
  endfunction

  function automatic int ocnt_exp(input int v);
`ifdef PSUM_OVF_CNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic chk(input string nm, input logic [ROWW-1:0] act, input logic [ROWW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cycle(input int k, input int base, input int n, input int skip);
    enable_in = '0;
    ps_in     = '0;
    for (int c = 0; c < COLS; c++) begin
      if (k - c >= 0 && k - c < n) begin
        if (c != skip) enable_in[c] = 1'b1;
        ps_in[c*PSW +: PSW] = PSW'((base + k - c)*100 + (c+1)*10);
      end
    end
  endtask

  // Sends n rows with the array's skew; the last row lands on the final edge.
  task automatic send(input int n, input int skip, input bit pop_last);
    int base;
    base = rid;
    for (int k = 0; k < n + COLS - 1; k++) begin
      drive_cycle(k, base, n, skip);
      if (pop_last && k == n + COLS - 2) row_ready = 1'b1;
      tick();
      if (pop_last) row_ready = 1'b0;
    end
    enable_in = '0;
    ps_in     = '0;
    rid += n;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic check_state(input string nm, input int cnt, input bit ovf, input bit skw,
                             input int oc, input int head);
    chk({nm, ".count"}, ROWW'(fifo_count), ROWW'(cnt));
    chk({nm, ".valid"}, ROWW'(row_valid), ROWW'(cnt != 0));
    chk({nm, ".ovf"},   ROWW'(overflow), ROWW'(ovf));
    chk({nm, ".skew"},  ROWW'(skew_err), ROWW'(skw));
    chk({nm, ".ocnt"},  ROWW'(ovf_cnt), ROWW'(ocnt_exp(oc)));
    chk({nm, ".head"},  row_data, (head < 0) ? '0 : mkrow(head));
  endtask

  task automatic flush_scn(input bit use_reset, input string nm);
    int base;
    pulse_clear();
    send(5, -1, 1'b0);
    row_ready = 1'b1;
    tick();
    row_ready = 1'b0;
    send(1, 2, 1'b0);
    check_state({nm, ".pre"}, 3, 1'b1, 1'b1, 1, rid - 5);
    base = rid;
    drive_cycle(0, base, 2, -1);
    tick();
    drive_cycle(1, base, 2, -1);
    tick();
    rid += 2;
    enable_in = '0;
    ps_in     = '0;
    if (use_reset) reset_n = 1'b0;
    else           clear   = 1'b1;
    tick();
    reset_n = 1'b1;
    clear   = 1'b0;
    check_state({nm, ".flushed"}, 0, 1'b0, 1'b0, 0, -1);
    for (int i = 0; i < 5; i++) tick();
    check_state({nm, ".idle"}, 0, 1'b0, 1'b0, 0, -1);
    send(1, -1, 1'b0);
    check_state({nm, ".fresh"}, 1, 1'b0, 1'b0, 0, rid - 1);
  endtask

  vec_t tbl [7];
  int   base;

  initial begin
    tbl[0] = '{clr:1, n:1, skip:-1, cnt:1, ovf:0, skw:0, ocnt:0, head:0};
    tbl[1] = '{clr:1, n:5, skip:-1, cnt:4, ovf:1, skw:0, ocnt:1, head:1};
    tbl[2] = '{clr:0, n:1, skip:2,  cnt:4, ovf:1, skw:1, ocnt:1, head:1};
    tbl[3] = '{clr:1, n:2, skip:-1, cnt:2, ovf:0, skw:0, ocnt:0, head:7};
    tbl[4] = '{clr:0, n:1, skip:2,  cnt:2, ovf:0, skw:1, ocnt:0, head:7};
    tbl[5] = '{clr:0, n:3, skip:-1, cnt:4, ovf:1, skw:1, ocnt:1, head:7};
    tbl[6] = '{clr:0, n:2, skip:-1, cnt:4, ovf:1, skw:1, ocnt:3, head:7};

    reset_n   = 1'b0;
    clear     = 1'b0;
    row_ready = 1'b0;
    enable_in = '0;
    ps_in     = '0;
    tick();
    tick();
    check_state("reset", 0, 1'b0, 1'b0, 0, -1);
    reset_n = 1'b1;
    tick();

    // Single skewed row: columns 0..3 carry 10,20,30,40 on cycles t..t+3.
    for (int c = 0; c < COLS; c++) begin
      enable_in = '0;
      ps_in     = '0;
      enable_in[c] = 1'b1;
      ps_in[c*PSW +: PSW] = PSW'((c+1)*10);
      if (c == COLS-1) chk("lat.before", ROWW'(row_valid), '0);
      tick();
    end
    enable_in = '0;
    ps_in     = '0;
    chk("lat.valid", ROWW'(row_valid), ROWW'(1));
    chk("lat.data",  row_data, {32'd40, 32'd30, 32'd20, 32'd10});
    chk("lat.count", ROWW'(fifo_count), ROWW'(1));
    chk("lat.skew",  ROWW'(skew_err), '0);

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].clr) pulse_clear();
      send(tbl[i].n, tbl[i].skip, 1'b0);
      check_state($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].ovf, tbl[i].skw,
                  tbl[i].ocnt, tbl[i].head);
    end

    // Streaming: six back-to-back rows drained as they arrive.
    pulse_clear();
    got.delete();
    base = rid;
    row_ready = 1'b1;
    send(6, -1, 1'b0);
    tick();
    tick();
    row_ready = 1'b0;
    chk("stream.n", ROWW'(got.size()), ROWW'(6));
    for (int i = 0; i < 6; i++)
      chk($sformatf("stream.row%0d", i), (i < got.size()) ? got[i] : '0, mkrow(base + i));
    check_state("stream.end", 0, 1'b0, 1'b0, 0, -1);

    // Push and pop on the same edge with the FIFO full.
    pulse_clear();
    base = rid;
    send(4, -1, 1'b0);
    check_state("pp.full", 4, 1'b0, 1'b0, 0, base);
    send(1, -1, 1'b1);
    check_state("pp.after", 4, 1'b0, 1'b0, 0, base + 1);
    got.delete();
    row_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    row_ready = 1'b0;
    chk("pp.n", ROWW'(got.size()), ROWW'(4));
    for (int i = 0; i < 4; i++)
      chk($sformatf("pp.row%0d", i), (i < got.size()) ? got[i] : '0, mkrow(base + 1 + i));
    chk("pp.empty", ROWW'(fifo_count), '0);

    flush_scn(1'b1, "rst");
    flush_scn(1'b0, "clr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
